// File: rtl/game_ctrl_if.sv
// Status/control bundle between the game controller and the video/attacker logic.
// The controller sits on the slave modport; the video side drives the master modport.
interface game_ctrl_if;
    logic        start;
    logic [16:0] H_count;
    logic [16:0] V_count;
    logic [4:0]  atk_over;
    logic        game_stop;
    logic        game_on;
    logic [2:0]  lives;
    logic [15:0] score;
    logic [15:0] hi_score;
    logic [1:0]  state;

    modport slave (
        input  start, H_count, V_count, atk_over,
        output game_stop, game_on, lives, score, hi_score, state
    );

    modport master (
        output start, H_count, V_count, atk_over,
        input  game_stop, game_on, lives, score, hi_score, state
    );
endinterface

// File: rtl/game_ctrl.sv
// Game flow controller: IDLE/PLAY/HIT/OVER sequencing, lives, frame-based score.
// Optional best-score tracking is built only when GAME_CTRL_HISCORE_EN is defined.
module game_ctrl #(
    parameter int LIVES_INIT = 3,
    parameter int HIT_FRAMES = 60,
    parameter int SCORE_DIV  = 60
) (
    input  logic         clk_65M,
    input  logic         clear,
    game_ctrl_if.slave   bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        HIT  = 2'd2,
        OVER = 2'd3
    } state_t;

    localparam logic [7:0]  DIV_LAST   = 8'(SCORE_DIV - 1);
    localparam logic [7:0]  HIT_LAST   = 8'(HIT_FRAMES - 1);
    localparam logic [2:0]  LIVES_LOAD = 3'(LIVES_INIT);
    localparam logic [15:0] SCORE_MAX  = 16'hFFFF;

    state_t      state_reg, state_next;
    logic [2:0]  lives_reg, lives_next;
    logic [15:0] score_reg, score_next;
    logic [7:0]  div_reg, div_next;
    logic [7:0]  hit_cnt_reg, hit_cnt_next;
    logic        game_stop_reg, game_on_reg;

    logic        start_meta_reg, start_sync_reg, start_prev_reg;
    logic [1:0]  arm_vld_reg;
    logic        armed_reg;

    logic        frame_tick;
    logic        start_pulse;
    logic        atk_hit;

    assign frame_tick = (bus.H_count == 17'd0) && (bus.V_count == 17'd0);
    assign atk_hit    = |bus.atk_over;

    // armed_reg only sets once the synchronized start has been seen low after
    // the pipeline refilled, so a button held through reset release cannot
    // masquerade as a rising edge.
    assign start_pulse = start_sync_reg & ~start_prev_reg & armed_reg;

    always_ff @(posedge clk_65M or negedge clear) begin
        if (!clear) begin
            start_meta_reg <= 1'b0;
            start_sync_reg <= 1'b0;
            start_prev_reg <= 1'b0;
            arm_vld_reg    <= 2'b00;
            armed_reg      <= 1'b0;
        end else begin
            start_meta_reg <= bus.start;
            start_sync_reg <= start_meta_reg;
            start_prev_reg <= start_sync_reg;
            arm_vld_reg    <= {arm_vld_reg[0], 1'b1};
            armed_reg      <= armed_reg | (arm_vld_reg[1] & ~start_sync_reg);
        end
    end

    always_comb begin
        state_next   = state_reg;
        lives_next   = lives_reg;
        score_next   = score_reg;
        div_next     = div_reg;
        hit_cnt_next = hit_cnt_reg;

        case (state_reg)
            IDLE, OVER: begin
                if (start_pulse) begin
                    state_next   = PLAY;
                    lives_next   = LIVES_LOAD;
                    score_next   = 16'd0;
                    div_next     = 8'd0;
                    hit_cnt_next = 8'd0;
                end
            end
            PLAY: begin
                if (frame_tick) begin
                    if (atk_hit) begin
                        // A hit wins over a coincident score increment.
                        lives_next   = lives_reg - 3'd1;
                        hit_cnt_next = 8'd0;
                        state_next   = (lives_reg <= 3'd1) ? OVER : HIT;
                    end else if (div_reg == DIV_LAST) begin
                        div_next = 8'd0;
                        if (score_reg != SCORE_MAX) begin
                            score_next = score_reg + 16'd1;
                        end
                    end else begin
                        div_next = div_reg + 8'd1;
                    end
                end
            end
            HIT: begin
                if (frame_tick) begin
                    if (hit_cnt_reg == HIT_LAST) begin
                        hit_cnt_next = 8'd0;
                        state_next   = PLAY;
                    end else begin
                        hit_cnt_next = hit_cnt_reg + 8'd1;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Status flags are decoded from the next state so they change on the same
    // edge as the state itself while still coming straight from flops.
    always_ff @(posedge clk_65M or negedge clear) begin
        if (!clear) begin
            state_reg     <= IDLE;
            lives_reg     <= 3'd0;
            score_reg     <= 16'd0;
            div_reg       <= 8'd0;
            hit_cnt_reg   <= 8'd0;
            game_stop_reg <= 1'b1;
            game_on_reg   <= 1'b0;
        end else begin
            state_reg     <= state_next;
            lives_reg     <= lives_next;
            score_reg     <= score_next;
            div_reg       <= div_next;
            hit_cnt_reg   <= hit_cnt_next;
            game_stop_reg <= (state_next != PLAY);
            game_on_reg   <= (state_next == PLAY);
        end
    end

`ifdef GAME_CTRL_HISCORE_EN
    logic [15:0] hi_score_reg;

    always_ff @(posedge clk_65M or negedge clear) begin
        if (!clear) begin
            hi_score_reg <= 16'd0;
        end else if ((state_reg == PLAY) && (state_next == OVER) &&
                     (score_reg > hi_score_reg)) begin
            hi_score_reg <= score_reg;
        end
    end

    assign bus.hi_score = hi_score_reg;
`else
    assign bus.hi_score = 16'd0;
`endif

    assign bus.state     = state_reg;
    assign bus.lives     = lives_reg;
    assign bus.score     = score_reg;
    assign bus.game_stop = game_stop_reg;
    assign bus.game_on   = game_on_reg;

endmodule

// File: tb/tb_game_ctrl.sv
// Directed bench for game_ctrl: main instance with default parameters plus a
// fast-scoring instance used to reach score saturation in bounded time.
module tb_game_ctrl;

`ifdef GAME_CTRL_HISCORE_EN
    localparam bit HI_EN = 1'b1;
`else
    localparam bit HI_EN = 1'b0;
`endif

    logic clk_65M = 1'b0;
    logic clear;
    logic clear_sat;
    int   tests_run    = 0;
    int   tests_failed = 0;

    game_ctrl_if g();
    game_ctrl_if gs();

    game_ctrl u_dut (
        .clk_65M (clk_65M),
        .clear   (clear),
        .bus     (g)
    );

    game_ctrl #(
        .LIVES_INIT (1),
        .HIT_FRAMES (1),
        .SCORE_DIV  (1)
    ) u_sat (
        .clk_65M (clk_65M),
        .clear   (clear_sat),
        .bus     (gs)
    );

    always #5 clk_65M = ~clk_65M;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
        $display("[TB] check %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk_65M);
        #1;
    endtask

    // Holding H/V at 0 makes every clock a frame tick.
    task automatic ticks(input int n);
        g.H_count = 17'd0;
        cycles(n);
        g.H_count = 17'd1;
    endtask

    task automatic hit(input logic [4:0] a);
        g.atk_over = a;
        ticks(1);
        g.atk_over = 5'd0;
    endtask

    task automatic restart();
        g.start = 1'b0;
        cycles(3);
        g.start = 1'b1;
        cycles(3);
    endtask

    initial begin
        clear       = 1'b1;
        clear_sat   = 1'b1;
        g.start     = 1'b0;
        g.H_count   = 17'd1;
        g.V_count   = 17'd0;
        g.atk_over  = 5'd0;
        gs.start    = 1'b0;
        gs.H_count  = 17'd1;
        gs.V_count  = 17'd0;
        gs.atk_over = 5'd0;

        // Asynchronous reset, checked before any clock edge.
        #2;
        clear     = 1'b0;
        clear_sat = 1'b0;
        #1;
        chk("rst_state", 32'(g.state), 32'd0);
        chk("rst_stop",  32'(g.game_stop), 32'd1);
        chk("rst_on",    32'(g.game_on), 32'd0);
        chk("rst_lives", 32'(g.lives), 32'd0);
        chk("rst_score", 32'(g.score), 32'd0);
        chk("rst_hi",    32'(g.hi_score), 32'd0);
        cycles(3);
        clear     = 1'b1;
        clear_sat = 1'b1;
        cycles(4);

        // Start latency: PLAY on the third edge after start is sampled.
        g.start = 1'b1;
        cycles(1);
        chk("start_e1", 32'(g.state), 32'd0);
        cycles(1);
        chk("start_e2", 32'(g.state), 32'd0);
        cycles(1);
        chk("start_state", 32'(g.state), 32'd1);
        chk("start_lives", 32'(g.lives), 32'd3);
        chk("start_score", 32'(g.score), 32'd0);
        chk("start_stop",  32'(g.game_stop), 32'd0);
        chk("start_on",    32'(g.game_on), 32'd1);

        // Scoring: one point per 60 ticks.
        ticks(59);
        chk("score_59", 32'(g.score), 32'd0);
        ticks(1);
        chk("score_60", 32'(g.score), 32'd1);
        ticks(60);
        chk("score_120", 32'(g.score), 32'd2);

        // atk_over off a frame tick is ignored.
        g.atk_over = 5'h1F;
        cycles(3);
        g.atk_over = 5'd0;
        chk("notick_lives", 32'(g.lives), 32'd3);
        chk("notick_state", 32'(g.state), 32'd1);

        // Divider at 30, then a two-bit hit costs one life.
        ticks(30);
        g.start = 1'b0;
        hit(5'b10100);
        chk("hit1_lives", 32'(g.lives), 32'd2);
        chk("hit1_state", 32'(g.state), 32'd2);
        chk("hit1_stop",  32'(g.game_stop), 32'd1);
        chk("hit1_on",    32'(g.game_on), 32'd0);
        chk("hit1_score", 32'(g.score), 32'd2);

        // In HIT: atk_over and a start edge are both ignored.
        g.atk_over = 5'h1F;
        g.start    = 1'b1;
        ticks(59);
        chk("hit1_hold_state", 32'(g.state), 32'd2);
        chk("hit1_hold_lives", 32'(g.lives), 32'd2);
        g.atk_over = 5'd0;
        ticks(1);
        chk("hit1_back_state", 32'(g.state), 32'd1);
        chk("hit1_back_stop",  32'(g.game_stop), 32'd0);

        // Divider preserved across HIT: 30 more ticks complete the point.
        ticks(29);
        chk("div_keep_29", 32'(g.score), 32'd2);
        ticks(1);
        chk("div_keep_30", 32'(g.score), 32'd3);

        // Hit coinciding with a score increment: hit wins.
        ticks(59);
        chk("pre_coinc_score", 32'(g.score), 32'd3);
        hit(5'b00001);
        chk("coinc_lives", 32'(g.lives), 32'd1);
        chk("coinc_score", 32'(g.score), 32'd3);
        chk("coinc_state", 32'(g.state), 32'd2);
        ticks(60);
        chk("hit2_back_state", 32'(g.state), 32'd1);

        // Third hit ends the game.
        hit(5'b01000);
        chk("over_state", 32'(g.state), 32'd3);
        chk("over_lives", 32'(g.lives), 32'd0);
        chk("over_score", 32'(g.score), 32'd3);
        chk("over_stop",  32'(g.game_stop), 32'd1);
        chk("over_on",    32'(g.game_on), 32'd0);
        chk("over_hi",    32'(g.hi_score), HI_EN ? 32'd3 : 32'd0);
        g.atk_over = 5'h1F;
        ticks(10);
        g.atk_over = 5'd0;
        chk("over_hold_score", 32'(g.score), 32'd3);
        chk("over_hold_lives", 32'(g.lives), 32'd0);
        chk("over_hold_state", 32'(g.state), 32'd3);

        // Second, lower-scoring game leaves hi_score alone.
        restart();
        chk("g2_state", 32'(g.state), 32'd1);
        chk("g2_lives", 32'(g.lives), 32'd3);
        chk("g2_score", 32'(g.score), 32'd0);
        ticks(10);
        hit(5'b00010);
        ticks(60);
        hit(5'b00010);
        ticks(60);
        hit(5'b00010);
        chk("g2_over_state", 32'(g.state), 32'd3);
        chk("g2_over_score", 32'(g.score), 32'd0);
        chk("g2_over_hi",    32'(g.hi_score), HI_EN ? 32'd3 : 32'd0);

        // Reset mid-HIT with start held high.
        restart();
        chk("g3_state", 32'(g.state), 32'd1);
        hit(5'b00100);
        chk("g3_hit_state", 32'(g.state), 32'd2);
        ticks(10);
        clear = 1'b0;
        #1;
        chk("midhit_rst_state", 32'(g.state), 32'd0);
        chk("midhit_rst_lives", 32'(g.lives), 32'd0);
        chk("midhit_rst_score", 32'(g.score), 32'd0);
        chk("midhit_rst_stop",  32'(g.game_stop), 32'd1);
        chk("midhit_rst_on",    32'(g.game_on), 32'd0);
        chk("midhit_rst_hi",    32'(g.hi_score), 32'd0);
        cycles(2);
        clear = 1'b1;
        cycles(20);
        chk("held_start_state", 32'(g.state), 32'd0);
        chk("held_start_stop",  32'(g.game_stop), 32'd1);
        restart();
        chk("fresh_start_state", 32'(g.state), 32'd1);
        chk("fresh_start_lives", 32'(g.lives), 32'd3);

        // Saturation on the fast-scoring instance (one point per tick).
        gs.start = 1'b1;
        cycles(3);
        chk("sat_start_state", 32'(gs.state), 32'd1);
        chk("sat_start_lives", 32'(gs.lives), 32'd1);
        gs.H_count = 17'd0;
        cycles(65534);
        chk("sat_fffe", 32'(gs.score), 32'h0000FFFE);
        cycles(120);
        chk("sat_ffff", 32'(gs.score), 32'h0000FFFF);
        gs.atk_over = 5'b00001;
        cycles(1);
        gs.atk_over = 5'd0;
        gs.H_count  = 17'd1;
        chk("sat_over_state", 32'(gs.state), 32'd3);
        chk("sat_over_score", 32'(gs.score), 32'h0000FFFF);
        chk("sat_over_hi",    32'(gs.hi_score), HI_EN ? 32'h0000FFFF : 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/game_ctrl.md
GAME_CTRL -- requirements
Module: game_ctrl

Interface
REQ-001 Parameter LIVES_INIT, default 3: lives loaded at game start; legal range 1..7.
REQ-002 Parameter HIT_FRAMES, default 60: frames game_stop is held after a non-fatal hit; legal range 1..255.
REQ-003 Parameter SCORE_DIV, default 60: frames per score point; legal range 1..255.
REQ-004 clk_65M  in  1  pixel clock; sole clock.
REQ-005 clear  in  1  asynchronous, active-low reset.
REQ-006 start  in  1  asynchronous start button level.
REQ-007 H_count  in  17  horizontal pixel counter.
REQ-008 V_count  in  17  vertical line counter.
REQ-009 atk_over  in  5  per-attacker collision flags, bit n = attacker n+1 gameN_over.
REQ-010 game_stop  out  1  registered; high forces all attackers to their start positions and clears their over flags.
REQ-011 game_on  out  1  registered; high only in PLAY.
REQ-012 lives  out  3  registered remaining lives.
REQ-013 score  out  16  registered score.
REQ-014 hi_score  out  16  registered best score.
REQ-015 state  out  2  current FSM state code: IDLE=0, PLAY=1, HIT=2, OVER=3.

Function
REQ-016 frame_tick SHALL be 1 exactly when H_count==0 and V_count==0.
REQ-017 start SHALL pass a 2-flop synchronizer; start_pulse SHALL be a one-cycle pulse on the synchronized rising edge.
REQ-018 State change on start SHALL occur on the edge following start_pulse: 3 clk_65M edges after start is first sampled high.
REQ-019 IDLE: game_stop=1, game_on=0; start_pulse -> PLAY with lives=LIVES_INIT, score=0, frame divider=0.
REQ-020 PLAY: game_stop=0, game_on=1; on frame_tick with |atk_over==0, the divider increments; when the divider reaches SCORE_DIV-1, it clears and score increments.
REQ-021 score SHALL saturate at 16'hFFFF, with no wrap.
REQ-022 PLAY, frame_tick with |atk_over==1: lives decrements; new lives==0 -> OVER, else -> HIT with hit counter=0.
REQ-023 When a hit and a score increment coincide on the same frame_tick, the hit takes priority and score is unchanged.
REQ-024 atk_over SHALL be sampled only on frame_tick in PLAY; it is ignored in all other states and cycles.
REQ-025 HIT: game_stop=1, game_on=0; the hit counter increments per frame_tick; after HIT_FRAMES ticks -> PLAY, with the divider preserved.
REQ-026 OVER: game_stop=1, game_on=0; score and lives are held; start_pulse -> PLAY, as in REQ-019.
REQ-027 start_pulse in PLAY or HIT SHALL be ignored.
REQ-028 Multiple simultaneous atk_over bits SHALL cost exactly one life.
REQ-029 All outputs SHALL be registered, with no combinational path from inputs to outputs.

Reset
REQ-030 clear low SHALL immediately force: state=IDLE, game_stop=1, game_on=0, lives=0, score=0, hi_score=0, synchronizer flops=0, counters=0.
REQ-031 Reset asserted mid-PLAY or mid-HIT SHALL abort with no transient outputs; after release the block waits in IDLE for a fresh start edge.
REQ-032 start held high through reset release SHALL NOT produce start_pulse.

Configuration
REQ-033 Macro GAME_CTRL_HISCORE_EN defined: on the edge entering OVER, hi_score <= score if score > hi_score; hi_score survives game restarts and is cleared only by clear.
REQ-034 GAME_CTRL_HISCORE_EN undefined: hi_score is constant 0 and no comparator or register is built.

Verification
REQ-035 Reset then start high: state=1, lives=3, score=0, game_stop=0 exactly 3 edges after start is sampled.
REQ-036 PLAY, 120 frame_ticks with no hit (SCORE_DIV=60): score=2.
REQ-037 PLAY, atk_over=5'b10100 on one tick: lives 3->2, state=2, game_stop high for 60 ticks, then state=1 with atk_over=0.
REQ-038 Third hit: lives=0, state=3, score frozen; with HISCORE_EN, hi_score=score; a second game scoring lower leaves hi_score unchanged.
REQ-039 Force score=16'hFFFE, run 120 ticks: score=16'hFFFF.
REQ-040 clear pulsed low mid-HIT with start held high: state=0, all counters 0, and state stays 0 until start toggles low then high.
